// File: rtl/reg_shadow_ctrl.sv
// Two-phase shadowed control register: SW must write a value twice to commit.
// An inverted shadow copy guards the committed value against corruption.
module reg_shadow_ctrl #(
   parameter int unsigned    DW     = 32,
   parameter logic [DW-1:0]  RESVAL = '0
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we,
   input  logic [DW-1:0] wd,
   input  logic          re,
   input  logic          de,
   input  logic [DW-1:0] d,
   output logic          phase,
   output logic          qe,
   output logic [DW-1:0] q,
   output logic [DW-1:0] qs,
   output logic          err_update,
   output logic          err_storage
);

   typedef enum logic {
      IDLE   = 1'b0,
      STAGED = 1'b1
   } phase_e;

   phase_e        phase_q, phase_d;
   logic [DW-1:0] staged_q, staged_d;
   logic [DW-1:0] q_q, q_d;
   logic [DW-1:0] shadow_q, shadow_d;
   logic          qe_q, qe_d;
   logic          err_update_q, err_update_d;
   logic          err_storage_q, err_storage_d;
   logic          confirm_match;
   logic          storage_bad;

   assign confirm_match = (wd == staged_q);
   assign storage_bad   = (q_q != ~shadow_q);

   always_comb begin
      phase_d       = phase_q;
      staged_d      = staged_q;
      q_d           = q_q;
      shadow_d      = shadow_q;
      qe_d          = 1'b0;
      err_update_d  = 1'b0;
      err_storage_d = err_storage_q | storage_bad;

      if (de) begin
         // HW write wins; a SW first-write still lands in staged.
         q_d      = d;
         shadow_d = ~d;
         phase_d  = IDLE;
         if (we && (phase_q == IDLE)) begin
            staged_d = wd;
         end
      end else if (we) begin
         unique case (phase_q)
            IDLE: begin
               staged_d = wd;
               phase_d  = STAGED;
            end
            STAGED: begin
               phase_d = IDLE;
               if (confirm_match) begin
                  q_d      = wd;
                  shadow_d = ~wd;
                  qe_d     = 1'b1;
               end else begin
                  err_update_d = 1'b1;
               end
            end
            default: phase_d = IDLE;
         endcase
      end else if (re && (phase_q == STAGED)) begin
         phase_d = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q       <= IDLE;
         staged_q      <= RESVAL;
         q_q           <= RESVAL;
         shadow_q      <= ~RESVAL;
         qe_q          <= 1'b0;
         err_update_q  <= 1'b0;
         err_storage_q <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         staged_q      <= staged_d;
         q_q           <= q_d;
         shadow_q      <= shadow_d;
         qe_q          <= qe_d;
         err_update_q  <= err_update_d;
         err_storage_q <= err_storage_d;
      end
   end

   assign phase       = phase_q;
   assign qe          = qe_q;
   assign q           = q_q;
   assign qs          = q_q;
   assign err_update  = err_update_q;
   assign err_storage = err_storage_q;

endmodule

// File: tb/tb_reg_shadow_ctrl.sv
// Bench for reg_shadow_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model of the two-write protocol.
module tb_reg_shadow_ctrl;

   localparam int unsigned   DW     = 32;
   localparam logic [DW-1:0] RESVAL = 32'h0000_00A5;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          we, re, de;
   logic [DW-1:0] wd, d;
   logic          phase, qe, err_update, err_storage;
   logic [DW-1:0] q, qs;

   int checks = 0;
   int errors = 0;

   // model state
   bit          m_pending;
   logic [DW-1:0] m_first;
   logic [DW-1:0] m_val;
   bit          m_qe, m_eu, m_es;

   logic [DW-1:0] force_val;

   always #5 clk_i = ~clk_i;

   reg_shadow_ctrl #(.DW(DW), .RESVAL(RESVAL)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .we(we), .wd(wd), .re(re), .de(de), .d(d),
      .phase(phase), .qe(qe), .q(q), .qs(qs),
      .err_update(err_update), .err_storage(err_storage)
   );

   task automatic model_reset();
      m_pending = 0;
      m_first   = RESVAL;
      m_val     = RESVAL;
      m_qe      = 0;
      m_eu      = 0;
      m_es      = 0;
   endtask

   // One bus cycle: drive at negedge, let the edge happen, advance the model.
   task automatic step(input bit w, input logic [DW-1:0] wv,
                       input bit r, input bit h, input logic [DW-1:0] hv);
      bit was_pending;
      @(negedge clk_i);
      we = w; wd = wv; re = r; de = h; d = hv;
      @(posedge clk_i);
      was_pending = m_pending;
      m_qe = 0;
      m_eu = 0;
      if (h) begin
         m_val     = hv;
         m_pending = 0;
         if (w && !was_pending) m_first = wv;
      end else if (w && !was_pending) begin
         m_first   = wv;
         m_pending = 1;
      end else if (w) begin
         m_pending = 0;
         if (wv == m_first) begin
            m_val = wv;
            m_qe  = 1;
         end else begin
            m_eu = 1;
         end
      end else if (r) begin
         m_pending = 0;
      end
      #1;
      we = 0; re = 0; de = 0;
   endtask

   task automatic test_reset();
      rst_ni = 0; we = 0; re = 0; de = 0; wd = '0; d = '0;
      model_reset();
      #12;
      checks++;
      if (q !== 32'hA5) begin errors++; $display("FAIL reset_q: got %h want %h", q, 32'hA5); end
      checks++;
      if (phase !== 1'b0 || qe !== 1'b0) begin
         errors++; $display("FAIL reset_phase_qe: got %b/%b want 0/0", phase, qe);
      end
      checks++;
      if (err_update !== 1'b0 || err_storage !== 1'b0) begin
         errors++; $display("FAIL reset_errs: got %b/%b want 0/0", err_update, err_storage);
      end
      checks++;
      if (dut.shadow_q !== 32'hFFFF_FF5A) begin
         errors++; $display("FAIL reset_shadow: got %h want %h", dut.shadow_q, 32'hFFFF_FF5A);
      end
      @(negedge clk_i);
      rst_ni = 1;
   endtask

   task automatic test_commit();
      step(1, 32'h1234_5678, 0, 0, '0);
      checks++;
      if (phase !== 1'b1 || q !== 32'hA5) begin
         errors++; $display("FAIL commit_stage: got phase %b q %h want 1 a5", phase, q);
      end
      step(1, 32'h1234_5678, 0, 0, '0);
      checks++;
      if (q !== 32'h1234_5678 || qe !== 1'b1 || phase !== 1'b0 || err_update !== 1'b0) begin
         errors++;
         $display("FAIL commit_done: got q %h qe %b ph %b eu %b want 12345678 1 0 0",
                  q, qe, phase, err_update);
      end
      checks++;
      if (dut.shadow_q !== ~32'h1234_5678) begin
         errors++; $display("FAIL commit_shadow: got %h want %h", dut.shadow_q, ~32'h1234_5678);
      end
      step(0, '0, 0, 0, '0);
      checks++;
      if (qe !== 1'b0 || err_update !== 1'b0) begin
         errors++; $display("FAIL commit_pulse: got qe %b eu %b want 0 0", qe, err_update);
      end
   endtask

   task automatic test_mismatch();
      // return q to RESVAL through the HW path first
      step(0, '0, 0, 1, RESVAL);
      step(1, 32'hDEAD_BEEF, 0, 0, '0);
      step(1, 32'hDEAD_BEEE, 0, 0, '0);
      checks++;
      if (err_update !== 1'b1 || q !== 32'hA5 || phase !== 1'b0 || qe !== 1'b0) begin
         errors++;
         $display("FAIL mismatch: got eu %b q %h ph %b qe %b want 1 a5 0 0",
                  err_update, q, phase, qe);
      end
      step(0, '0, 0, 0, '0);
      checks++;
      if (err_update !== 1'b0) begin
         errors++; $display("FAIL mismatch_pulse: got %b want 0", err_update);
      end
      step(1, 32'h1, 0, 0, '0);
      step(1, 32'h1, 0, 0, '0);
      checks++;
      if (q !== 32'h1 || qe !== 1'b1) begin
         errors++; $display("FAIL mismatch_recover: got q %h qe %b want 1 1", q, qe);
      end
   endtask

   task automatic test_abort();
      step(1, 32'h55, 0, 0, '0);
      step(0, '0, 1, 0, '0);
      checks++;
      if (phase !== 1'b0 || err_update !== 1'b0) begin
         errors++; $display("FAIL abort_re: got ph %b eu %b want 0 0", phase, err_update);
      end
      step(1, 32'h55, 0, 0, '0);
      checks++;
      if (phase !== 1'b1 || q !== 32'h1 || qe !== 1'b0) begin
         errors++; $display("FAIL abort_restage: got ph %b q %h qe %b want 1 1 0", phase, q, qe);
      end
      step(0, '0, 1, 0, '0);
      step(0, '0, 1, 0, '0);
      checks++;
      if (phase !== 1'b0) begin
         errors++; $display("FAIL re_idle: got ph %b want 0", phase);
      end
   endtask

   task automatic test_hw_override();
      step(1, 32'h77, 0, 0, '0);
      step(1, 32'h77, 0, 1, 32'h99);
      checks++;
      if (q !== 32'h99 || qs !== 32'h99 || qe !== 1'b0 || err_update !== 1'b0 || phase !== 1'b0) begin
         errors++;
         $display("FAIL hw_override: got q %h qs %h qe %b eu %b ph %b want 99 99 0 0 0",
                  q, qs, qe, err_update, phase);
      end
      // HW write alongside a first write: staged updates, phase stays idle
      step(1, 32'hABCD, 0, 1, 32'h42);
      step(1, 32'h1111, 0, 0, '0);
      step(1, 32'hABCD, 0, 0, '0);
      checks++;
      if (err_update !== 1'b1 || q !== 32'h42) begin
         errors++; $display("FAIL hw_first: got eu %b q %h want 1 42", err_update, q);
      end
   endtask

   task automatic test_reset_mid();
      step(1, 32'hCAFE, 0, 0, '0);
      @(negedge clk_i);
      rst_ni = 0;
      model_reset();
      #2;
      checks++;
      if (phase !== 1'b0 || q !== RESVAL) begin
         errors++; $display("FAIL reset_mid: got ph %b q %h want 0 a5", phase, q);
      end
      @(negedge clk_i);
      rst_ni = 1;
      step(1, 32'hCAFE, 0, 0, '0);
      checks++;
      if (phase !== 1'b1 || qe !== 1'b0) begin
         errors++; $display("FAIL reset_discard: got ph %b qe %b want 1 0", phase, qe);
      end
      step(0, '0, 1, 0, '0);
   endtask

   task automatic test_random();
      logic [DW-1:0] pool [3];
      logic [DW-1:0] wv, hv;
      bit w, r, h;
      pool[0] = $urandom;
      pool[1] = $urandom;
      pool[2] = pool[0] ^ 32'h8000_0000;
      for (int i = 0; i < 400; i++) begin
         w  = ($urandom_range(0, 9) < 6);
         r  = ($urandom_range(0, 9) < 2);
         h  = ($urandom_range(0, 9) < 1);
         wv = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 2)];
         hv = $urandom;
         step(w, wv, r, h, hv);
         checks++;
         if (q !== m_val || qs !== m_val) begin
            errors++; $display("FAIL rnd_q[%0d]: got q %h qs %h want %h", i, q, qs, m_val);
         end
         checks++;
         if (phase !== m_pending) begin
            errors++; $display("FAIL rnd_phase[%0d]: got %b want %b", i, phase, m_pending);
         end
         checks++;
         if (qe !== m_qe || err_update !== m_eu) begin
            errors++;
            $display("FAIL rnd_pulse[%0d]: got qe %b eu %b want %b %b", i, qe, err_update, m_qe, m_eu);
         end
         checks++;
         if (err_storage !== m_es || dut.shadow_q !== ~m_val) begin
            errors++;
            $display("FAIL rnd_store[%0d]: got es %b sh %h want %b %h",
                     i, err_storage, dut.shadow_q, m_es, ~m_val);
         end
         checks++;
         if (m_pending && dut.staged_q !== m_first) begin
            errors++; $display("FAIL rnd_staged[%0d]: got %h want %h", i, dut.staged_q, m_first);
         end
      end
   endtask

   task automatic test_storage_err();
      step(0, '0, 1, 0, '0);
      @(negedge clk_i);
      checks++;
      if (err_storage !== 1'b0) begin
         errors++; $display("FAIL storage_pre: got %b want 0", err_storage);
      end
      force_val = ~m_val ^ 32'h1;
      force dut.shadow_q = force_val;
      @(posedge clk_i);
      #1;
      release dut.shadow_q;
      checks++;
      if (err_storage !== 1'b1) begin
         errors++; $display("FAIL storage_set: got %b want 1", err_storage);
      end
      step(1, 32'h3C3C, 0, 0, '0);
      step(1, 32'h3C3C, 0, 0, '0);
      step(0, '0, 0, 1, 32'h5);
      step(0, '0, 0, 0, '0);
      checks++;
      if (err_storage !== 1'b1 || q !== 32'h5) begin
         errors++; $display("FAIL storage_sticky: got es %b q %h want 1 5", err_storage, q);
      end
      @(negedge clk_i);
      rst_ni = 0;
      model_reset();
      #2;
      checks++;
      if (err_storage !== 1'b0) begin
         errors++; $display("FAIL storage_clear: got %b want 0", err_storage);
      end
      @(negedge clk_i);
      rst_ni = 1;
   endtask

   initial begin
      test_reset();
      test_commit();
      test_mismatch();
      test_abort();
      test_hw_override();
      test_reset_mid();
      test_random();
      test_storage_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
